// File: rtl/vram_arb.sv
// Arbitrated single-port video RAM: scanout reads (primary) always win, CPU
// requests (secondary) go through a one-entry hold buffer so none are lost.
module vram_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_req,
  input  logic [ADDR_W-1:0]     p_addr,
  output logic                  p_rvalid,
  output logic [DATA_W-1:0]     p_dout,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_we,
  input  logic [DATA_W/8-1:0]   s_wmask,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_din,
  output logic                  s_rvalid,
  output logic [DATA_W-1:0]     s_dout
);
  localparam int MASK_W = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  // Handshake: a secondary request transfers at a rising edge where
  // s_valid && s_ready; s_valid and its payload must stay stable until then.
  // s_ready depends only on the registered hold flag and p_req.

  logic                hold_full_q, hold_full_d;
  logic                hold_we_q, hold_we_d;
  logic [MASK_W-1:0]   hold_mask_q, hold_mask_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_din_q, hold_din_d;

  logic                s_accept;
  logic                capture;
  logic                hold_issue;

  logic                iss_rd;
  logic                iss_port_p;
  logic                iss_we;
  logic [MASK_W-1:0]   iss_mask;
  logic [ADDR_W-1:0]   iss_addr;
  logic [DATA_W-1:0]   iss_din;

  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [MASK_W-1:0]   ram_mask_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                rd1_v_q, rd1_p_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   ram_rdata_q;
  logic                rd2_v_q, rd2_p_q;

  logic                p_rvalid_q, s_rvalid_q;
  logic [DATA_W-1:0]   p_dout_q, s_dout_q;

  assign s_ready  = !hold_full_q || !p_req;
  assign s_accept = s_valid && s_ready;

  always_comb begin
    iss_rd      = 1'b0;
    iss_port_p  = 1'b0;
    iss_we      = 1'b0;
    iss_mask    = '0;
    iss_addr    = '0;
    iss_din     = '0;
    hold_issue  = 1'b0;
    if (p_req) begin
      iss_rd     = 1'b1;
      iss_port_p = 1'b1;
      iss_addr   = p_addr;
    end else if (hold_full_q) begin
      hold_issue = 1'b1;
      iss_we     = hold_we_q;
      iss_rd     = !hold_we_q;
      iss_mask   = hold_mask_q;
      iss_addr   = hold_addr_q;
      iss_din    = hold_din_q;
    end else if (s_accept) begin
      iss_we     = s_we;
      iss_rd     = !s_we;
      iss_mask   = s_wmask;
      iss_addr   = s_addr;
      iss_din    = s_din;
    end

    // An accepted request that cannot go straight to the RAM parks in hold.
    capture     = s_accept && (p_req || hold_full_q);
    hold_full_d = capture ? 1'b1 : (hold_issue ? 1'b0 : hold_full_q);
    hold_we_d   = capture ? s_we    : hold_we_q;
    hold_mask_d = capture ? s_wmask : hold_mask_q;
    hold_addr_d = capture ? s_addr  : hold_addr_q;
    hold_din_d  = capture ? s_din   : hold_din_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_we_q   <= 1'b0;
      hold_mask_q <= '0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_mask_q  <= '0;
      ram_din_q   <= '0;
      rd1_v_q     <= 1'b0;
      rd1_p_q     <= 1'b0;
      rd2_v_q     <= 1'b0;
      rd2_p_q     <= 1'b0;
      p_rvalid_q  <= 1'b0;
      s_rvalid_q  <= 1'b0;
      p_dout_q    <= '0;
      s_dout_q    <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_we_q   <= hold_we_d;
      hold_mask_q <= hold_mask_d;
      hold_addr_q <= hold_addr_d;
      hold_din_q  <= hold_din_d;

      ram_addr_q  <= iss_addr;
      ram_we_q    <= iss_we;
      ram_mask_q  <= iss_mask;
      ram_din_q   <= iss_din;
      rd1_v_q     <= iss_rd;
      rd1_p_q     <= iss_port_p;

      rd2_v_q     <= rd1_v_q;
      rd2_p_q     <= rd1_p_q;

      // Only the tagged port's data register moves; the other one holds.
      p_rvalid_q  <= rd2_v_q && rd2_p_q;
      s_rvalid_q  <= rd2_v_q && !rd2_p_q;
      if (rd2_v_q && rd2_p_q) begin
        p_dout_q <= ram_rdata_q;
      end
      if (rd2_v_q && !rd2_p_q) begin
        s_dout_q <= ram_rdata_q;
      end
    end
  end

  // RAM array: contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (ram_we_q && ram_mask_q[b]) begin
        mem[ram_addr_q][8*b +: 8] <= ram_din_q[8*b +: 8];
      end
    end
    ram_rdata_q <= mem[ram_addr_q];
  end

  assign p_rvalid = p_rvalid_q;
  assign s_rvalid = s_rvalid_q;
  assign p_dout   = p_dout_q;
  assign s_dout   = s_dout_q;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: transaction-level model (request queue + word array)
// predicts s_ready, strobes and read data every cycle.
module tb_vram_arb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int MASK_W = DATA_W / 8;

  logic                clk;
  logic                rst;
  logic                p_req;
  logic [ADDR_W-1:0]   p_addr;
  logic                p_rvalid;
  logic [DATA_W-1:0]   p_dout;
  logic                s_valid;
  logic                s_ready;
  logic                s_we;
  logic [MASK_W-1:0]   s_wmask;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_din;
  logic                s_rvalid;
  logic [DATA_W-1:0]   s_dout;

  vram_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_addr(p_addr), .p_rvalid(p_rvalid), .p_dout(p_dout),
    .s_valid(s_valid), .s_ready(s_ready), .s_we(s_we), .s_wmask(s_wmask),
    .s_addr(s_addr), .s_din(s_din), .s_rvalid(s_rvalid), .s_dout(s_dout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic                we;
    logic [MASK_W-1:0]   mask;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
  } sreq_t;

  typedef struct {
    int                  due;
    logic                port_p;
    logic [DATA_W-1:0]   data;
  } exp_t;

  sreq_t             sq[$];
  exp_t              exp_q[$];
  logic [DATA_W-1:0] mem_m [32];
  logic [DATA_W-1:0] p_dout_m, s_dout_m;
  int                cyc;
  int                n_checks, n_pass;
  logic              rdy_seen, acc_seen, p_rv_seen, s_rv_seen;
  int                p_strobes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic m_ready();
    return (sq.size() == 0) || !p_req;
  endfunction

  task automatic model_reset();
    sq.delete();
    exp_q.delete();
    p_dout_m = '0;
    s_dout_m = '0;
  endtask

  // One edge of the reference: queue accepted request, pick one access by priority.
  task automatic model_edge();
    sreq_t r;
    exp_t  e;
    int    a;
    if (s_valid && m_ready()) begin
      r.we = s_we; r.mask = s_wmask; r.addr = s_addr; r.din = s_din;
      sq.push_back(r);
    end
    e.due = cyc + 1 + 2;
    if (p_req) begin
      a = int'(p_addr[4:0]);
      e.port_p = 1'b1;
      e.data   = mem_m[a];
      exp_q.push_back(e);
    end else if (sq.size() > 0) begin
      r = sq.pop_front();
      a = int'(r.addr[4:0]);
      if (r.we) begin
        for (int b = 0; b < MASK_W; b++)
          if (r.mask[b]) mem_m[a][8*b +: 8] = r.din[8*b +: 8];
      end else begin
        e.port_p = 1'b0;
        e.data   = mem_m[a];
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic ep, es;
    exp_t e;
    #1;
    rdy_seen = s_ready;
    acc_seen = s_valid && s_ready;
    check("s_ready", s_ready, m_ready());
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ep = 1'b0;
    es = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.port_p) begin ep = 1'b1; p_dout_m = e.data; end
      else begin es = 1'b1; s_dout_m = e.data; end
    end
    p_rv_seen = p_rvalid;
    s_rv_seen = s_rvalid;
    if (p_rvalid) p_strobes++;
    check("p_rvalid", p_rvalid, ep);
    check("s_rvalid", s_rvalid, es);
    check("p_dout", p_dout, p_dout_m);
    check("s_dout", s_dout, s_dout_m);
  endtask

  task automatic cpu_req(input logic we, input logic [MASK_W-1:0] mask,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
    int n;
    n = 0;
    s_valid = 1'b1; s_we = we; s_wmask = mask; s_addr = addr; s_din = din;
    do begin
      step();
      n++;
    end while (!acc_seen && n < 50);
    check("cpu_accept", acc_seen, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic wait_s_strobe();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_rv_seen && n < 20);
    check("s_strobe_wait", s_rv_seen, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] prior;
  int                cpu_st;
  logic              p_prev;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; p_strobes = 0;
    rst = 1'b1; p_req = 1'b0; p_addr = '0;
    s_valid = 1'b0; s_we = 1'b0; s_wmask = '0; s_addr = '0; s_din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_p_dout", p_dout, 0);
    check("rst_s_ready", s_ready, 1);
    rst = 1'b0;

    // idle after reset
    repeat (10) step();
    check("idle_p_rvalid", p_rvalid, 0);
    check("idle_s_rvalid", s_rvalid, 0);
    check("idle_s_dout", s_dout, 0);

    // preload the addresses the bench uses
    for (int a = 0; a < 32; a++)
      cpu_req(1'b1, 2'b11, ADDR_W'(a), DATA_W'($urandom_range(1, 16'hFFFF)));

    // write then read, latency check
    cpu_req(1'b1, 2'b11, 13'h0005, 16'hBEEF);
    cpu_req(1'b0, 2'b00, 13'h0005, 16'h0000);
    step();
    check("lat_early_s_rvalid", s_rv_seen, 0);
    step();
    check("lat_s_rvalid", s_rv_seen, 1);
    check("lat_p_rvalid", p_rv_seen, 0);
    check("rd_beef", s_dout, 16'hBEEF);

    // byte mask merge
    cpu_req(1'b1, 2'b11, 13'h0006, 16'h1234);
    cpu_req(1'b1, 2'b10, 13'h0006, 16'hAB00);
    cpu_req(1'b0, 2'b00, 13'h0006, 16'h0000);
    wait_s_strobe();
    check("mask_ab34", s_dout, 16'hAB34);

    // contention: 8 primary reads while CPU writes then reads 0x10
    repeat (3) step();
    cpu_st = 0;
    p_strobes = 0;
    for (int i = 0; i < 8; i++) begin
      p_req = 1'b1;
      p_addr = ADDR_W'(i);
      if (cpu_st == 0) begin
        s_valid = 1'b1; s_we = 1'b1; s_wmask = 2'b11; s_addr = 13'h0010; s_din = 16'h00FF;
      end else begin
        s_valid = 1'b1; s_we = 1'b0; s_wmask = 2'b00; s_addr = 13'h0010; s_din = '0;
      end
      step();
      check($sformatf("cont_ready_%0d", i), rdy_seen, (i == 0));
      if (acc_seen) cpu_st++;
    end
    p_req = 1'b0;
    step();
    check("cont_drop_ready", rdy_seen, 1);
    check("cont_drop_accept", acc_seen, 1);
    s_valid = 1'b0;
    wait_s_strobe();
    check("cont_rd_00ff", s_dout, 16'h00FF);
    repeat (2) step();
    check("cont_p_strobes", p_strobes, 8);

    // random interleave of primary pulses and CPU traffic
    p_prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      p_req = p_prev ? 1'b0 : ($urandom_range(0, 99) < 40);
      p_prev = p_req;
      p_addr = ADDR_W'($urandom_range(0, 31));
      if (!s_valid && $urandom_range(0, 99) < 60) begin
        s_valid = 1'b1;
        s_we    = ($urandom_range(0, 99) < 35);
        s_wmask = MASK_W'($urandom_range(0, 3));
        s_addr  = ADDR_W'($urandom_range(0, 7));
        s_din   = DATA_W'($urandom);
      end
      step();
      if (acc_seen) s_valid = 1'b0;
    end
    p_req = 1'b0;
    s_valid = 1'b0;
    repeat (6) step();
    check("rand_drain", exp_q.size(), 0);

    // asynchronous reset with a full hold entry and two reads in flight
    prior = mem_m[9];
    p_req = 1'b1; p_addr = 13'h0001;
    s_valid = 1'b1; s_we = 1'b1; s_wmask = 2'b11; s_addr = 13'h0009; s_din = ~prior;
    step();
    check("rst_setup_accept", acc_seen, 1);
    s_valid = 1'b0;
    p_addr = 13'h0002;
    step();
    check("rst_setup_full", s_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_p_rvalid", p_rvalid, 0);
    check("arst_s_rvalid", s_rvalid, 0);
    check("arst_p_dout", p_dout, 0);
    check("arst_s_dout", s_dout, 0);
    check("arst_s_ready", s_ready, 1);
    model_reset();
    p_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("arst_hold_p_rvalid", p_rvalid, 0);
    check("arst_hold_s_rvalid", s_rvalid, 0);
    rst = 1'b0;
    repeat (6) step();
    cpu_req(1'b0, 2'b00, 13'h0009, 16'h0000);
    wait_s_strobe();
    check("arst_hold_discarded", s_dout, prior);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
# vram_arb

Parametrised, arbitrated video RAM for the display/CPU memory path. It wraps one single-port synchronous RAM of 2**ADDR_W words. A read-only primary port, driven by the display scanout, always has priority. A secondary port, driven by the CPU, uses a valid/ready handshake, byte-masked writes and a one-entry hold buffer, so that a CPU request is never lost while scanout owns the RAM. Both ports return read data with a registered valid strobe at fixed latency.

## Interface
Parameters:
- DATA_W, 16, word width; must be a multiple of 8
- ADDR_W, 13, word address width; depth = 2**ADDR_W

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- p_req  in  1  primary read request; sampled every edge
- p_addr  in  ADDR_W  primary read address
- p_rvalid  out  1  one-cycle strobe: p_dout holds primary read data
- p_dout  out  DATA_W  primary read data; holds its value between strobes
- s_valid  in  1  secondary request valid
- s_ready  out  1  secondary request accepted at an edge where s_valid && s_ready
- s_we  in  1  1 = write, 0 = read
- s_wmask  in  DATA_W/8  per-byte write enable; bit i controls bits [8i+7:8i]
- s_addr  in  ADDR_W  secondary address
- s_din  in  DATA_W  secondary write data
- s_rvalid  out  1  one-cycle strobe: s_dout holds secondary read data
- s_dout  out  DATA_W  secondary read data; holds its value between strobes

## Operation
- Hold buffer: one register holding {we, wmask, addr, din} plus a `full` flag.
- s_ready = !full || !p_req. This is combinational from the registered `full` flag and p_req only.
- Per-edge arbitration, in priority order:
  - p_req = 1: primary read issued.
  - else, full: hold entry issued.
  - else, s_valid && s_ready: the incoming request is issued directly.
  - else: idle; no RAM access and no write.
- Accept handling, whenever s_valid && s_ready:
  - If the incoming request is not issued this edge, it is written into hold and full = 1.
  - full clears when its entry is issued, unless a new request is captured at the same edge.
- Secondary requests issue strictly in acceptance order. A read following a write to the same address returns the written data.
- Writes: only bytes with s_wmask = 1 are updated. A write with mask 0 is a no-op access. Writes produce no response.
- Reads: each issued read carries a port tag (P or S) down the pipeline. It produces exactly one p_rvalid or one s_rvalid.
- RAM contents are not reset and are undefined until written.

## Timing
- Pipeline, for a request issued at edge N:
  - Edge N: registers ram_addr, ram_we, ram_mask, ram_din and the read tag.
  - Edge N+1: RAM access; read data and tag registered.
  - Edge N+2: p_dout/s_dout loaded and the matching rvalid asserted for exactly one cycle.
- Read latency is therefore 3 edges from issue to strobe. For a hold-buffered request, count from its issue edge.
- Throughput: one access per cycle. Back-to-back primary reads stream one p_rvalid per cycle.
- Under sustained p_req, the secondary port accepts exactly one request and then holds s_ready = 0 until p_req drops.
- When p_req drops with full = 1: the hold entry issues at the next edge, and s_ready = 1 in that same cycle, so a new request is captured into hold without a bubble.
- Only the strobe of the tagged port changes its dout. The other port's dout holds its value.
- Reset, asynchronous and taking effect immediately:
  - p_rvalid = 0, s_rvalid = 0, p_dout = 0, s_dout = 0.
  - full = 0, hence s_ready = 1.
  - Pipeline tags and ram_we cleared.
- Reset mid-operation: in-flight reads produce no strobe. A pending hold entry is discarded and never written.
- Simultaneous events:
  - p_req together with an s_valid accepted into an empty hold: primary issues and the secondary request is buffered.
  - p_req together with full: the hold entry waits and s_ready = 0.

## Test plan
- Reset then idle 10 cycles: all outputs 0, s_ready = 1, no strobes.
- CPU write 0xBEEF @0x0005 mask 2'b11, then read @0x0005 with p_req = 0: s_rvalid = 1 with s_dout = 0xBEEF exactly 3 edges after the read is accepted; p_rvalid stays 0.
- Byte mask: write 0x1234 with mask 2'b11, then 0xAB00 with mask 2'b10, then read: s_dout = 0xAB34.
- Contention: p_req held high for 8 cycles over addresses 0..7 while the CPU presents write 0x00FF @0x0010 then read @0x0010:
  - first request accepted, s_ready = 0 for the remaining p_req cycles;
  - 8 consecutive p_rvalid strobes with correct data;
  - after p_req drops, the write issues, then the read returns 0x00FF.
- Ordering and tagging: interleave single-cycle p_req pulses with a CPU read stream (random stimulus, 2000 cycles) checked against a reference model. Required: every read gets exactly one strobe on its own port with model-correct data, and the secondary issue order equals the acceptance order.
- Async reset asserted mid-cycle with full = 1 and 2 reads in flight: outputs clear without a clock edge; no strobes afterwards; the hold entry's address keeps its prior contents.
